ctx_cost_write_sched: RTL and testbench

CTX_COST_WRITE_SCHED -- requirements
Module: ctx_cost_write_sched

---
 rtl/ctx_cost_write_sched_pkg.sv | 16 +
 rtl/rr_arb2.sv | 33 +++
 rtl/ctx_cost_write_sched.sv | 128 ++++++++++++
 tb/tb_ctx_cost_write_sched.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctx_cost_write_sched_pkg.sv
// Shared types and constants for the context bit-cost write scheduler.
package ctx_cost_write_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int DEF_NUM_CTX = 8;
    localparam int DEF_COST_W  = 16;
    localparam int CTX_W       = 8;
    // Sweep counter holds ctx in its upper bits and bin in bit 0 (up to 32 contexts).
    localparam int SWEEP_W     = 6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from valids, pointer moves on transfer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic favour_b;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid[0] && (!valid[1] || !favour_b)) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            favour_b <= 1'b0;
        end else if (grant[0] && valid[0]) begin
            favour_b <= 1'b1;
        end else if (grant[1] && valid[1]) begin
            favour_b <= 1'b0;
        end
    end

endmodule

// File: rtl/ctx_cost_write_sched.sv
// Schedules writes into the context bit-cost register file: an init sweep
// followed by round-robin arbitration between the CABAC and RDO requesters.
module ctx_cost_write_sched
    import ctx_cost_write_sched_pkg::*;
#(
    parameter int NUM_CTX = DEF_NUM_CTX,
    parameter int COST_W  = DEF_COST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    input  logic [COST_W-1:0] init_cost,
    output logic [4:0]        init_ctx,
    output logic              init_bin,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [CTX_W-1:0]  a_ctx,
    input  logic              a_bin,
    input  logic [COST_W-1:0] a_cost,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [CTX_W-1:0]  b_ctx,
    input  logic              b_bin,
    input  logic [COST_W-1:0] b_cost,
    output logic              we,
    output logic [CTX_W-1:0]  ctx_addr,
    output logic              bin_val,
    output logic [COST_W-1:0] bit_cost_in,
    output logic              busy,
    output logic              init_done,
    output logic              drop_err
);

    localparam logic [SWEEP_W-1:0] LAST_ENTRY = SWEEP_W'(2 * NUM_CTX - 1);

    state_t              state_q;
    state_t              state_d;
    logic [SWEEP_W-1:0]  sweep_q;
    logic                sweep_last;
    logic                arb_en;
    logic [1:0]          grant;
    logic [CTX_W-1:0]    sel_ctx;
    logic                sel_bin;
    logic [COST_W-1:0]   sel_cost;

    assign sweep_last = (sweep_q == LAST_ENTRY);
    assign init_ctx   = sweep_q[SWEEP_W-1:1];
    assign init_bin   = sweep_q[0];
    assign busy       = (state_q == ST_INIT);
    assign a_ready    = grant[0];
    assign b_ready    = grant[1];

    // A restart request in RUN blocks grants that cycle so stalled requesters
    // resume only after the new sweep has finished.
    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_start) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (sweep_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (init_start) state_d = ST_INIT;
                else            arb_en  = rst_n;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .valid ({b_valid, a_valid}),
        .grant (grant)
    );

    always_comb begin
        sel_ctx  = a_ctx;
        sel_bin  = a_bin;
        sel_cost = a_cost;
        if (grant[1]) begin
            sel_ctx  = b_ctx;
            sel_bin  = b_bin;
            sel_cost = b_cost;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sweep_q     <= '0;
            we          <= 1'b0;
            init_done   <= 1'b0;
            drop_err    <= 1'b0;
            ctx_addr    <= '0;
            bin_val     <= 1'b0;
            bit_cost_in <= '0;
        end else begin
            state_q   <= state_d;
            we        <= 1'b0;
            init_done <= 1'b0;
            drop_err  <= 1'b0;
            sweep_q   <= (state_q == ST_INIT) ? sweep_q + 1'b1 : '0;
            if (state_q == ST_INIT) begin
                we          <= 1'b1;
                ctx_addr    <= CTX_W'(init_ctx);
                bin_val     <= init_bin;
                bit_cost_in <= init_cost;
                init_done   <= sweep_last;
            end else if (|grant) begin
                // Out-of-range contexts are consumed but never reach the regfile.
                if (sel_ctx < CTX_W'(NUM_CTX)) begin
                    we          <= 1'b1;
                    ctx_addr    <= sel_ctx;
                    bin_val     <= sel_bin;
                    bit_cost_in <= sel_cost;
                end else begin
                    drop_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctx_cost_write_sched.sv
// Scoreboard bench for ctx_cost_write_sched: expected writes are queued at
// stimulus time and matched against what appears on the write port.
module tb_ctx_cost_write_sched;

    localparam int NUM_CTX = 8;
    localparam int COST_W  = 16;

    typedef struct packed {
        logic        we;
        logic        drop;
        logic        done;
        logic [7:0]  ctx;
        logic        bin;
        logic [15:0] cost;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic [15:0] init_cost;
    logic [4:0]  init_ctx;
    logic        init_bin;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [7:0]  a_ctx = '0;
    logic        a_bin = 1'b0;
    logic [15:0] a_cost = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [7:0]  b_ctx = '0;
    logic        b_bin = 1'b0;
    logic [15:0] b_cost = '0;
    logic        we;
    logic [7:0]  ctx_addr;
    logic        bin_val;
    logic [15:0] bit_cost_in;
    logic        busy;
    logic        init_done;
    logic        drop_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    wr_t         mon_r;
    wr_t         e;
    wr_t         o;
    logic        ptr_m = 1'b0;
    logic [7:0]  lw_ctx = '0;
    logic        lw_bin = 1'b0;
    logic [15:0] lw_cost = '0;
    logic [15:0] obs_rf [0:31][0:1];

    ctx_cost_write_sched #(.NUM_CTX(NUM_CTX), .COST_W(COST_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_start  (init_start),
        .init_cost   (init_cost),
        .init_ctx    (init_ctx),
        .init_bin    (init_bin),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_ctx       (a_ctx),
        .a_bin       (a_bin),
        .a_cost      (a_cost),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_ctx       (b_ctx),
        .b_bin       (b_bin),
        .b_cost      (b_cost),
        .we          (we),
        .ctx_addr    (ctx_addr),
        .bin_val     (bin_val),
        .bit_cost_in (bit_cost_in),
        .busy        (busy),
        .init_done   (init_done),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Init table lookup seen by the DUT: {ctx, 0, bin, ctx}
    assign init_cost = {init_ctx, 5'b00000, init_bin, init_ctx};

    function automatic logic [15:0] icost(input int c, input int b);
        logic [4:0] c5;
        logic       b1;
        c5 = c[4:0];
        b1 = b[0];
        return {c5, 5'b00000, b1, c5};
    endfunction

    always @(negedge clk) begin
        if (we === 1'b1 || drop_err === 1'b1 || init_done === 1'b1) begin
            mon_r.we   = we;
            mon_r.drop = drop_err;
            mon_r.done = init_done;
            mon_r.ctx  = ctx_addr;
            mon_r.bin  = bin_val;
            mon_r.cost = bit_cost_in;
            mon_r.cyc  = cyc;
            obs_q.push_back(mon_r);
        end
    end

    task automatic push_write(input logic is_drop, input logic [7:0] c, input logic b,
                              input logic [15:0] v, input logic done, input int at);
        wr_t r;
        if (!is_drop) begin
            lw_ctx  = c;
            lw_bin  = b;
            lw_cost = v;
        end
        r.we   = !is_drop;
        r.drop = is_drop;
        r.done = done;
        r.ctx  = lw_ctx;
        r.bin  = lw_bin;
        r.cost = lw_cost;
        r.cyc  = at;
        exp_q.push_back(r);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic req_cycle(input logic av, input logic [7:0] ac, input logic ab, input logic [15:0] acost,
                             input logic bv, input logic [7:0] bc, input logic bb, input logic [15:0] bcost);
        logic ga;
        logic gb;
        int   cur;
        @(posedge clk); #1;
        a_valid = av; a_ctx = ac; a_bin = ab; a_cost = acost;
        b_valid = bv; b_ctx = bc; b_bin = bb; b_cost = bcost;
        cur = cyc;
        ga = av && (!bv || !ptr_m);
        gb = bv && !ga;
        @(negedge clk);
        vectors++;
        if ({a_ready, b_ready} !== {ga, gb}) begin
            miscompares++;
            $display("[TB] FAIL ready_grant cycle %0d: actual a=%b b=%b, required a=%b b=%b",
                     cur, a_ready, b_ready, ga, gb);
        end
        if (ga) begin
            push_write(ac >= 8'(NUM_CTX), ac, ab, acost, 1'b0, cur + 1);
            ptr_m = 1'b1;
        end else if (gb) begin
            push_write(bc >= 8'(NUM_CTX), bc, bb, bcost, 1'b0, cur + 1);
            ptr_m = 1'b0;
        end
    endtask

    task automatic do_init(input logic with_b);
        int c0;
        @(posedge clk); #1;
        init_start = 1'b1;
        if (with_b) b_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        vectors++;
        if ({a_ready, b_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL init_start_ready: actual %b%b, required 00", a_ready, b_ready);
        end
        @(posedge clk); #1;
        init_start = 1'b0;
        for (int k = 0; k < 2 * NUM_CTX; k++) begin
            push_write(1'b0, 8'(k / 2), 1'(k % 2), icost(k / 2, k % 2), (k == 2 * NUM_CTX - 1), c0 + 2 + k);
            @(negedge clk);
            vectors++;
            if ({busy, a_ready, b_ready} !== 3'b100 || init_ctx !== 5'(k / 2) || init_bin !== 1'(k % 2)) begin
                miscompares++;
                $display("[TB] FAIL init_cycle %0d: actual busy=%b rdy=%b%b entry=%0d/%b, required busy=1 rdy=00 entry=%0d/%0d",
                         k, busy, a_ready, b_ready, init_ctx, init_bin, k / 2, k % 2);
            end
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_after_init: actual %b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({we, busy, init_done, drop_err, a_ready, b_ready} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: actual %b, required 000000",
                     {we, busy, init_done, drop_err, a_ready, b_ready});
        end
        vectors++;
        if ({ctx_addr, bin_val, bit_cost_in, init_ctx, init_bin} !== 31'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: actual ctx=%h bin=%b cost=%h entry=%h/%b, required zeros",
                     ctx_addr, bin_val, bit_cost_in, init_ctx, init_bin);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({a_ready, b_ready, we} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL idle_no_accept %0d: actual rdy=%b%b we=%b, required 000",
                         i, a_ready, b_ready, we);
            end
        end
        go_idle();
        obs_q.delete();
    endtask

    task automatic test_init();
        do_init(1'b0);
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL init_write missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL init_write: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL init_write extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_arbitration();
        repeat (4) req_cycle(1'b1, 8'd1, 1'b0, 16'h1111, 1'b1, 8'd2, 1'b0, 16'h2222);
        go_idle();
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL arb_write missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL arb_write: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL arb_write extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_drop();
        req_cycle(1'b1, 8'd100, 1'b0, 16'hDEAD, 1'b0, 8'd0, 1'b0, 16'h0000);
        go_idle();
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL drop_event missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL drop_event: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drop_event extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (obs_rf[3][b] !== icost(3, b)) begin
                miscompares++;
                $display("[TB] FAIL ctx3_unchanged bin %0d: actual %h, required %h", b, obs_rf[3][b], icost(3, b));
            end
        end
    endtask

    task automatic test_same_target();
        req_cycle(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 8'd5, 1'b0, 16'h5555);
        req_cycle(1'b1, 8'd5, 1'b1, 16'hFACE, 1'b1, 8'd5, 1'b1, 16'hBEEF);
        req_cycle(1'b0, 8'd5, 1'b1, 16'hFACE, 1'b1, 8'd5, 1'b1, 16'hBEEF);
        go_idle();
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL same_target missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL same_target: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL same_target extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
        vectors++;
        if (obs_rf[5][1] !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL last_writer_wins: actual %h, required BEEF", obs_rf[5][1]);
        end
    endtask

    task automatic test_init_restart();
        b_ctx = 8'd6; b_bin = 1'b1; b_cost = 16'h6B6B;
        do_init(1'b1);
        vectors++;
        if ({a_ready, b_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL restart_resume: actual a=%b b=%b, required a=0 b=1", a_ready, b_ready);
        end
        push_write(1'b0, 8'd6, 1'b1, 16'h6B6B, 1'b0, cyc + 1);
        ptr_m = 1'b0;
        go_idle();
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL restart_write missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL restart_write: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL restart_write extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_init();
        int c0;
        @(posedge clk); #1;
        init_start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        init_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_write(1'b0, 8'(k / 2), 1'(k % 2), icost(k / 2, k % 2), 1'b0, c0 + 2 + k);
        end
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = 1'b0;
        lw_ctx = '0; lw_bin = 1'b0; lw_cost = '0;
        @(negedge clk);
        vectors++;
        if ({we, busy, init_done} !== 3'b000 || ctx_addr !== 8'h00 || bit_cost_in !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL mid_init_reset: actual we=%b busy=%b done=%b ctx=%h cost=%h, required zeros",
                     we, busy, init_done, ctx_addr, bit_cost_in);
        end
        a_valid = 1'b1; a_ctx = 8'd3; a_bin = 1'b1; a_cost = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (a_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_ignore %0d: actual %b, required 0", i, a_ready);
            end
        end
        go_idle();
        do_init(1'b0);
        req_cycle(1'b1, 8'd3, 1'b1, 16'h3333, 1'b0, 8'd0, 1'b0, 16'h0000);
        go_idle();
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL mid_init_write missing: actual none, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o.we) obs_rf[o.ctx[4:0]][o.bin] = o.cost;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL mid_init_write: actual %h, required %h", o, e);
                end
            end
        end
        if (obs_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL mid_init_write extra: actual %0d, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        $display("[TB] ctx_cost_write_sched bench start");
        test_reset();
        test_init();
        test_arbitration();
        test_drop();
        test_same_target();
        test_init_restart();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
